// File: rtl/iris_pkg.sv
// Shared definitions for the Iris classifier datapath.
// Holds the default feature width and sample-counter width, the beat-order
// enum used by the feature loader, and a packed struct of one full sample.
package iris_pkg;

    localparam int unsigned IRIS_N     = 8;   // feature width in bits
    localparam int unsigned IRIS_CW    = 16;  // delivered-sample counter width
    localparam int unsigned IRIS_NFEAT = 4;   // features per sample

    // Beat order of the serial feature stream
    typedef enum logic [1:0] {
        SEPAL_LENGTH = 2'd0,
        SEPAL_WIDTH  = 2'd1,
        PETAL_LENGTH = 2'd2,
        PETAL_WIDTH  = 2'd3
    } feat_idx_e;

    // One assembled sample; sepal_length occupies the most significant bits
    typedef struct packed {
        logic [IRIS_N-1:0] sepal_length;
        logic [IRIS_N-1:0] sepal_width;
        logic [IRIS_N-1:0] petal_length;
        logic [IRIS_N-1:0] petal_width;
    } iris_sample_t;

endpackage

// File: rtl/iris_feature_loader.sv
// Iris feature loader: collects a serial stream of N-bit features (one per
// beat, valid/ready) into a four-feature sample and holds it on the parallel
// m_* buses under valid/ready until the consumer takes it.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   s_data/s_valid/s_ready   feature beat input handshake
//   s_last                   end-of-sample marker (checked only with
//                            IRIS_LOADER_LAST_EN defined, ignored otherwise)
//   m_sepal_length..m_petal_width, m_valid, m_ready
//                            assembled sample output handshake
//   sample_cnt               samples delivered, modulo 2^CW
//   frame_err                sticky framing error (constant 0 without
//                            IRIS_LOADER_LAST_EN)
//
// Build option: define IRIS_LOADER_LAST_EN to check s_last framing.
module iris_feature_loader
    import iris_pkg::*;
#(
    parameter int unsigned N     = IRIS_N,
    parameter int unsigned NFEAT = IRIS_NFEAT,
    parameter int unsigned CW    = IRIS_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  s_data,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic          s_last,
    output logic [N-1:0]  m_sepal_length,
    output logic [N-1:0]  m_sepal_width,
    output logic [N-1:0]  m_petal_length,
    output logic [N-1:0]  m_petal_width,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [CW-1:0] sample_cnt,
    output logic          frame_err
);

    feat_idx_e    idx;
    logic [N-1:0] stg [0:NFEAT-2];
    logic         xfer;
    logic         early_end;
    logic         missing_end;

    // Only the final beat has to wait for the held sample to drain; earlier
    // beats of the next sample are staged while the current one is held.
    assign s_ready = rst || !(idx == PETAL_WIDTH && m_valid && !m_ready);
    assign xfer    = s_valid && s_ready;

`ifdef IRIS_LOADER_LAST_EN
    assign early_end   = s_last && (idx != PETAL_WIDTH);
    assign missing_end = !s_last && (idx == PETAL_WIDTH);
`else
    logic unused_s_last;
    assign unused_s_last = s_last;
    assign early_end     = 1'b0;
    assign missing_end   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            idx            <= SEPAL_LENGTH;
            stg            <= '{default: '0};
            m_sepal_length <= '0;
            m_sepal_width  <= '0;
            m_petal_length <= '0;
            m_petal_width  <= '0;
            m_valid        <= 1'b0;
            sample_cnt     <= '0;
            frame_err      <= 1'b0;
        end else begin
            if (m_valid && m_ready) begin
                m_valid    <= 1'b0;
                sample_cnt <= sample_cnt + CW'(1);
            end
            if (xfer) begin
                if (early_end) begin
                    // Partial sample is abandoned; next beat starts a new one
                    idx       <= SEPAL_LENGTH;
                    frame_err <= 1'b1;
                end else begin
                    if (missing_end) begin
                        frame_err <= 1'b1;
                    end
                    case (idx)
                        SEPAL_LENGTH: begin
                            stg[0] <= s_data;
                            idx    <= SEPAL_WIDTH;
                        end
                        SEPAL_WIDTH: begin
                            stg[1] <= s_data;
                            idx    <= PETAL_LENGTH;
                        end
                        PETAL_LENGTH: begin
                            stg[2] <= s_data;
                            idx    <= PETAL_WIDTH;
                        end
                        PETAL_WIDTH: begin
                            // Overrides the clear above so back-to-back
                            // samples keep m_valid high without a bubble
                            m_sepal_length <= stg[0];
                            m_sepal_width  <= stg[1];
                            m_petal_length <= stg[2];
                            m_petal_width  <= s_data;
                            m_valid        <= 1'b1;
                            idx            <= SEPAL_LENGTH;
                        end
                        default: idx <= SEPAL_LENGTH;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_iris_feature_loader.sv
// Self-checking bench for iris_feature_loader. Beats are driven by the
// stimulus thread; a reference model collects accepted beats into samples
// and queues the expected sample, and a monitor compares the DUT outputs
// against the queue head every cycle. Built with CW=4 so the delivered-
// sample counter wraps in a short run.
module tb_iris_feature_loader;
    import iris_pkg::*;

    localparam int unsigned N  = 8;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          s_last = 1'b0;
    logic [N-1:0]  m_sepal_length, m_sepal_width, m_petal_length, m_petal_width;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [CW-1:0] sample_cnt;
    logic          frame_err;

    iris_feature_loader #(.N(N), .NFEAT(4), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
        .m_sepal_length(m_sepal_length), .m_sepal_width(m_sepal_width),
        .m_petal_length(m_petal_length), .m_petal_width(m_petal_width),
        .m_valid(m_valid), .m_ready(m_ready),
        .sample_cnt(sample_cnt), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    iris_sample_t exp_q[$];
    iris_sample_t cur = '0;
    logic [N-1:0] bq[$];
    int unsigned  cnt = 0;
    logic         ferr = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_accept(input logic [N-1:0] d, input logic l);
`ifdef IRIS_LOADER_LAST_EN
        if (l && bq.size() < 3) begin
            bq.delete();
            ferr = 1'b1;
            return;
        end
        if (!l && bq.size() == 3) ferr = 1'b1;
`else
        if (l) begin end
`endif
        bq.push_back(d);
        if (bq.size() == 4) begin
            cur = {bq[0], bq[1], bq[2], bq[3]};
            exp_q.push_back(cur);
            bq.delete();
        end
    endtask

    // Monitor first (state produced by earlier edges), then model update
    // for the edge that follows this negedge.
    always @(negedge clk) begin
        iris_sample_t e;
        logic         es;
        e = (exp_q.size() != 0) ? exp_q[0] : cur;
        chk("m_valid", m_valid, 32'(exp_q.size() != 0));
        chk("sepal_length", m_sepal_length, e.sepal_length);
        chk("sepal_width", m_sepal_width, e.sepal_width);
        chk("petal_length", m_petal_length, e.petal_length);
        chk("petal_width", m_petal_width, e.petal_width);
        chk("sample_cnt", sample_cnt, cnt % (1 << CW));
        chk("frame_err", frame_err, ferr);
        if (rst) begin
            chk("s_ready_rst", s_ready, 1);
            exp_q.delete();
            bq.delete();
            cur  = '0;
            cnt  = 0;
            ferr = 1'b0;
        end else begin
            es = !(bq.size() == 3 && exp_q.size() != 0 && !m_ready);
            chk("s_ready", s_ready, es);
            if (exp_q.size() != 0 && m_ready) begin
                void'(exp_q.pop_front());
                cnt++;
            end
            if (s_valid && es) model_accept(s_data, s_last);
        end
    end

    // Drive one beat and hold it until accepted (bounded wait)
    task automatic beat(input logic [N-1:0] d, input logic l);
        int unsigned t = 0;
        s_data  = d;
        s_last  = l;
        s_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            t++;
            if (t > 200) begin
                n_chk++;
                n_fail++;
                $display("FAIL beat_timeout: got s_ready=0 for %0d cycles expected acceptance", t);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int unsigned n);
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = N'($urandom);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic last_bit(input int unsigned i);
`ifdef IRIS_LOADER_LAST_EN
        return i == 3;
`else
        return 1'($urandom_range(0, 1));
`endif
    endfunction

    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] c, input logic [N-1:0] d);
        beat(a, last_bit(0));
        beat(b, last_bit(1));
        beat(c, last_bit(2));
        beat(d, last_bit(3));
    endtask

    logic rnd_rdy = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_rdy) m_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int unsigned c0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_cnt", sample_cnt, 0);
        chk("reset_valid", m_valid, 0);

        // Single sample
        send(40, 60, 70, 20);
        idle(2);

        // Backpressure: sample A held, sample B's beat 3 stalls
        m_ready = 1'b0;
        send(1, 2, 3, 4);
        beat(90, last_bit(0));
        beat(100, last_bit(1));
        beat(160, last_bit(2));
        fork
            beat(60, last_bit(3));
            begin
                repeat (4) @(posedge clk);
                #1 m_ready = 1'b1;
            end
        join
        idle(3);

        // Back-to-back: 8 samples in exactly 32 cycles
        c0 = cyc;
        for (int i = 0; i < 8; i++)
            send(N'(i * 16 + 1), N'(i * 16 + 2), N'(i * 16 + 3), N'(i * 16 + 4));
        chk("b2b_cycles", cyc - c0, 32);
        idle(3);

        // Randomised traffic with random consumer stalls
        rnd_rdy = 1'b1;
        for (int i = 0; i < 240; i++) begin
            beat(N'($urandom), last_bit(i % 4));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        rnd_rdy = 1'b0;
        m_ready = 1'b1;
        idle(3);

        // Reset mid-sample
        beat(5, last_bit(0));
        beat(6, last_bit(1));
        s_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("midrst_valid", m_valid, 0);
        chk("midrst_data", m_sepal_length, 0);
        chk("midrst_cnt", sample_cnt, 0);
        send(10, 20, 30, 40);
        idle(2);

        // Counter wrap: 16 deliveries since reset brings it back to 0
        for (int i = 0; i < 15; i++) send(N'(i), 8'hAA, 8'h55, N'(255 - i));
        idle(3);
        chk("wrap_cnt", sample_cnt, 0);

`ifdef IRIS_LOADER_LAST_EN
        // Early end on beat 1, then a correctly framed sample
        beat(11, 1'b0);
        beat(12, 1'b1);
        idle(2);
        chk("early_valid", m_valid, 0);
        chk("early_ferr", frame_err, 1);
        send(7, 8, 9, 10);
        idle(2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected completion");
        $fatal(1, "timeout");
    end

endmodule
